uart_temp_rx: RTL and testbench

Receive-side counterpart of the temperature UART link. It deserialises the 8N1 UART stream produced by the sensor transmitter and parses the 4-byte temperature packet. It then presents the validated 16-bit reading to host-side logic with a one-cycle valid strobe. It sits on the board/FPGA end of the link, driven from the sensor chip's `uart_tx_o` pin.

---
 rtl/uart_temp_rx.sv | 205 ++++++++++++++++++++
 tb/tb_uart_temp_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_temp_rx.sv
// 8N1 UART receiver with temperature packet parser (SYNC, MSB, LSB, CHK).
// Delivers validated 16-bit readings to host logic with one-cycle strobes.
module uart_temp_rx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          TIMEOUT_BITS = 20,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx_i,
    output logic [7:0]  byte_data_o,
    output logic        byte_valid_o,
    output logic        frame_err_o,
    output logic [15:0] temp_data_o,
    output logic        temp_valid_o,
    output logic        chk_err_o,
    output logic        busy_o
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int TLIM = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW   = $clog2(TLIM + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_e;
    typedef enum logic [1:0] {P_SYNC, P_MSB, P_LSB, P_CHK} pkt_state_e;

    logic            sync1_q, sync1_d, sync2_q, sync2_d;
    logic            rxs, start_det;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            bvalid_q, bvalid_d;
    logic            ferr_q, ferr_d;
    pkt_state_e      pstate_q, pstate_d;
    logic [7:0]      msb_q, msb_d, lsb_q, lsb_d;
    logic [15:0]     temp_q, temp_d;
    logic            tvalid_q, tvalid_d;
    logic            cerr_q, cerr_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;

    assign rxs       = sync2_q;
    assign start_det = (state_q == S_IDLE) && !rxs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            bvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            pstate_q <= P_SYNC;
            msb_q    <= '0;
            lsb_q    <= '0;
            temp_q   <= '0;
            tvalid_q <= 1'b0;
            cerr_q   <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            bvalid_q <= bvalid_d;
            ferr_q   <= ferr_d;
            pstate_q <= pstate_d;
            msb_q    <= msb_d;
            lsb_q    <= lsb_d;
            temp_q   <= temp_d;
            tvalid_q <= tvalid_d;
            cerr_q   <= cerr_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Bit engine: cnt starts at 1 on each transition so the compare value equals the sample offset.
    always_comb begin
        sync1_d  = uart_rx_i;
        sync2_d  = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        bvalid_d = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = CW'(1);
                end
            end
            S_START: begin
                if (cnt_q == CW'(HALF)) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = CW'(1);
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT)) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = CW'(1);
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT)) begin
                    if (rxs) begin
                        byte_d   = shift_q;
                        bvalid_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Packet parser; a received byte or frame error takes priority over the idle timeout.
    always_comb begin
        pstate_d = pstate_q;
        msb_d    = msb_q;
        lsb_d    = lsb_q;
        temp_d   = temp_q;
        tvalid_d = 1'b0;
        cerr_d   = 1'b0;
        to_cnt_d = to_cnt_q;
        if (pstate_q == P_SYNC || state_q != S_IDLE || start_det) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        if (ferr_q) begin
            pstate_d = P_SYNC;
        end else if (bvalid_q) begin
            case (pstate_q)
                P_SYNC: if (byte_q == SYNC_BYTE) pstate_d = P_MSB;
                P_MSB: begin
                    msb_d    = byte_q;
                    pstate_d = P_LSB;
                end
                P_LSB: begin
                    lsb_d    = byte_q;
                    pstate_d = P_CHK;
                end
                P_CHK: begin
                    if (byte_q == (SYNC_BYTE ^ msb_q ^ lsb_q)) begin
                        temp_d   = {msb_q, lsb_q};
                        tvalid_d = 1'b1;
                    end else begin
                        cerr_d = 1'b1;
                    end
                    pstate_d = P_SYNC;
                end
                default: pstate_d = P_SYNC;
            endcase
        end else if (pstate_q != P_SYNC && state_q == S_IDLE && !start_det
                     && to_cnt_q == TW'(TLIM - 1)) begin
            pstate_d = P_SYNC;
            to_cnt_d = '0;
        end
    end

    assign byte_data_o  = byte_q;
    assign byte_valid_o = bvalid_q;
    assign frame_err_o  = ferr_q;
    assign temp_data_o  = temp_q;
    assign temp_valid_o = tvalid_q;
    assign chk_err_o    = cerr_q;
    assign busy_o       = (state_q != S_IDLE) || !rxs;

endmodule

// File: tb/tb_uart_temp_rx.sv
// Directed bench for uart_temp_rx: bytes, packets, checksum, framing, timeout, back-to-back and reset.
module tb_uart_temp_rx;

    localparam int C = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx_i = 1'b1;
    logic [7:0]  byte_data_o;
    logic        byte_valid_o;
    logic        frame_err_o;
    logic [15:0] temp_data_o;
    logic        temp_valid_o;
    logic        chk_err_o;
    logic        busy_o;

    uart_temp_rx #(.CLKS_PER_BIT(C), .TIMEOUT_BITS(4), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .uart_rx_i(uart_rx_i),
        .byte_data_o(byte_data_o), .byte_valid_o(byte_valid_o), .frame_err_o(frame_err_o),
        .temp_data_o(temp_data_o), .temp_valid_o(temp_valid_o), .chk_err_o(chk_err_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int nbv = 0, nfe = 0, ntv = 0, nce = 0, viol = 0;
    logic [7:0] rx_bytes[$];
    int rx_cyc[$];
    int tx_cyc[$];
    logic pbv = 0, pfe = 0, ptv = 0, pce = 0;

    // Capture pulses mid-cycle and flag overlapping or stretched strobes.
    always @(negedge clk) begin
        if (byte_valid_o) begin
            nbv++;
            rx_bytes.push_back(byte_data_o);
            rx_cyc.push_back(cyc);
        end
        if (frame_err_o) nfe++;
        if (temp_valid_o) ntv++;
        if (chk_err_o) nce++;
        if ((byte_valid_o && frame_err_o) || (byte_valid_o && pbv) || (frame_err_o && pfe)
            || (temp_valid_o && ptv) || (chk_err_o && pce))
            viol++;
        pbv = byte_valid_o;
        pfe = frame_err_o;
        ptv = temp_valid_o;
        pce = chk_err_o;
    end

    task automatic drive_bit(input logic v);
        uart_rx_i = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        tx_cyc.push_back(cyc);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic send_packet(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (byte_data_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte_data got %h want 00", byte_data_o); end
        checks++; if (temp_data_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_temp_data got %h want 0000", temp_data_o); end
        checks++; if ({byte_valid_o, frame_err_o, temp_valid_o, chk_err_o} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pulses got %b want 0000", {byte_valid_o, frame_err_o, temp_valid_o, chk_err_o}); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b want 0", busy_o); end
    endtask

    task automatic test_clean_packet;
        int b0, t0, f0, c0;
        logic [7:0] exp [4] = '{8'hA5, 8'h01, 8'h9C, 8'h38};
        b0 = nbv; t0 = ntv; f0 = nfe; c0 = nce;
        rx_bytes.delete();
        send_packet(8'hA5, 8'h01, 8'h9C, 8'h38);
        idle_bits(2);
        checks++; if (nbv - b0 != 4) begin errors++; $display("[TB] FAIL clean_byte_count got %0d want 4", nbv - b0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_bytes.size() <= i || rx_bytes[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL clean_byte%0d got %h want %h", i, (rx_bytes.size() > i) ? rx_bytes[i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (ntv - t0 != 1) begin errors++; $display("[TB] FAIL clean_temp_valid got %0d want 1", ntv - t0); end
        checks++; if (temp_data_o !== 16'h019C) begin errors++; $display("[TB] FAIL clean_temp_data got %h want 019C", temp_data_o); end
        checks++; if (nfe - f0 + nce - c0 != 0) begin errors++; $display("[TB] FAIL clean_errors got %0d want 0", nfe - f0 + nce - c0); end
    endtask

    task automatic test_checksum_error;
        int t0, c0;
        t0 = ntv; c0 = nce;
        send_packet(8'hA5, 8'h01, 8'h9C, 8'h39);
        idle_bits(2);
        checks++; if (nce - c0 != 1) begin errors++; $display("[TB] FAIL chk_err_count got %0d want 1", nce - c0); end
        checks++; if (ntv - t0 != 0) begin errors++; $display("[TB] FAIL chk_no_valid got %0d want 0", ntv - t0); end
        checks++; if (temp_data_o !== 16'h019C) begin errors++; $display("[TB] FAIL chk_temp_kept got %h want 019C", temp_data_o); end
        send_packet(8'hA5, 8'h00, 8'h19, 8'hBC);
        idle_bits(2);
        checks++; if (temp_data_o !== 16'h0019) begin errors++; $display("[TB] FAIL chk_next_good got %h want 0019", temp_data_o); end
        checks++; if (ntv - t0 != 1) begin errors++; $display("[TB] FAIL chk_next_valid got %0d want 1", ntv - t0); end
    endtask

    task automatic test_timeout;
        int t0, c0;
        t0 = ntv; c0 = nce;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b1);
        idle_bits(5);
        send_byte(8'h34, 1'b1);
        send_byte(8'h87, 1'b1);
        idle_bits(2);
        checks++; if (ntv - t0 != 0) begin errors++; $display("[TB] FAIL timeout_no_valid got %0d want 0", ntv - t0); end
        checks++; if (nce - c0 != 0) begin errors++; $display("[TB] FAIL timeout_no_chk got %0d want 0", nce - c0); end
        checks++; if (temp_data_o !== 16'h0019) begin errors++; $display("[TB] FAIL timeout_temp_kept got %h want 0019", temp_data_o); end
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_packet(8'hA5, 8'h12, 8'h34, 8'h83);
        idle_bits(2);
        checks++; if (temp_data_o !== 16'h1234) begin errors++; $display("[TB] FAIL resync_temp got %h want 1234", temp_data_o); end
        checks++; if (ntv - t0 != 1) begin errors++; $display("[TB] FAIL resync_valid got %0d want 1", ntv - t0); end
    endtask

    task automatic test_framing;
        int b0, f0, t0, c0;
        b0 = nbv; f0 = nfe;
        uart_rx_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 uart_rx_i = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy got %b want 0", busy_o); end
        checks++; if (nbv - b0 + nfe - f0 != 0) begin errors++; $display("[TB] FAIL glitch_pulses got %0d want 0", nbv - b0 + nfe - f0); end
        idle_bits(1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        b0 = nbv; f0 = nfe; t0 = ntv; c0 = nce;
        send_byte(8'h55, 1'b0);
        uart_rx_i = 1'b0;
        repeat (2 * C) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL break_busy got %b want 1", busy_o); end
        uart_rx_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL break_release_busy got %b want 0", busy_o); end
        checks++; if (nfe - f0 != 1) begin errors++; $display("[TB] FAIL frame_err_count got %0d want 1", nfe - f0); end
        checks++; if (nbv - b0 != 0) begin errors++; $display("[TB] FAIL frame_no_valid got %0d want 0", nbv - b0); end
        checks++; if (byte_data_o !== 8'h01) begin errors++; $display("[TB] FAIL frame_byte_kept got %h want 01", byte_data_o); end
        idle_bits(1);
        send_packet(8'hA5, 8'h01, 8'h9C, 8'h38);
        idle_bits(2);
        checks++; if (temp_data_o !== 16'h019C) begin errors++; $display("[TB] FAIL frame_resync_temp got %h want 019C", temp_data_o); end
        checks++; if (ntv - t0 != 1 || nce - c0 != 0) begin errors++; $display("[TB] FAIL frame_resync_pulses got tv=%0d ce=%0d want tv=1 ce=0", ntv - t0, nce - c0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [4] = '{8'hC3, 8'h00, 8'hFF, 8'h5A};
        int lat;
        rx_bytes.delete();
        rx_cyc.delete();
        tx_cyc.delete();
        send_packet(exp[0], exp[1], exp[2], exp[3]);
        idle_bits(1);
        checks++; if (rx_bytes.size() != 4) begin errors++; $display("[TB] FAIL b2b_count got %0d want 4", rx_bytes.size()); end
        for (int i = 0; i < 4; i++) begin
            lat = (rx_cyc.size() > i) ? rx_cyc[i] - tx_cyc[i] : -1;
            checks++;
            if (rx_bytes.size() <= i || rx_bytes[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL b2b_byte%0d got %h want %h", i, (rx_bytes.size() > i) ? rx_bytes[i] : 8'hxx, exp[i]);
            end
            checks++;
            if (lat < 154 || lat > 156) begin
                errors++;
                $display("[TB] FAIL b2b_latency%0d got %0d want 155+-1", i, lat);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int b0, f0, t0, c0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        uart_rx_i = 1'b1;
        repeat (C / 2) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        checks++; if (byte_data_o !== 8'h00 || temp_data_o !== 16'h0000) begin errors++; $display("[TB] FAIL rst_mid_data got %h/%h want 00/0000", byte_data_o, temp_data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy_o); end
        b0 = nbv; f0 = nfe; t0 = ntv; c0 = nce;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        idle_bits(3);
        checks++; if (nbv - b0 + nfe - f0 + ntv - t0 + nce - c0 != 0) begin errors++; $display("[TB] FAIL rst_release_pulses got %0d want 0", nbv - b0 + nfe - f0 + ntv - t0 + nce - c0); end
        send_byte(8'h3C, 1'b1);
        idle_bits(2);
        checks++; if (nbv - b0 != 1) begin errors++; $display("[TB] FAIL rst_after_count got %0d want 1", nbv - b0); end
        checks++; if (byte_data_o !== 8'h3C) begin errors++; $display("[TB] FAIL rst_after_byte got %h want 3C", byte_data_o); end
    endtask

    task automatic test_pulse_rules;
        checks++; if (viol != 0) begin errors++; $display("[TB] FAIL pulse_rules got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_clean_packet();
        test_checksum_error();
        test_timeout();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
        test_pulse_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
